// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Single-outstanding instruction fetch FSM with redirect latch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         redirect_pending_q, redirect_pending_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic         redirect_bad_q, redirect_bad_d;
  logic         req_valid_q, req_valid_d;
  logic [31:0]  addr_q, addr_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         fetch_err_q, fetch_err_d;

  logic         w_redir_in;
  logic         w_pend;
  logic [31:0]  w_tgt;
  logic         w_bad;
  logic         w_go_req;
  logic [31:0]  w_go_pc;

  // A redirect arriving this cycle is folded in as if already latched.
  assign w_redir_in = redirect && (state_q != ST_ERR);
  assign w_pend     = redirect_pending_q || w_redir_in;
  assign w_tgt      = w_redir_in ? next_pc : redirect_pc_q;
  assign w_bad      = redirect_bad_q || (w_redir_in && (next_pc[1:0] != 2'b00));

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    redirect_pending_d = w_pend;
    redirect_pc_d      = w_tgt;
    redirect_bad_d     = w_bad;
    req_valid_d        = req_valid_q;
    addr_d             = addr_q;
    inst_valid_d       = inst_valid_q;
    inst_d             = inst_q;
    inst_pc_d          = inst_pc_q;
    fetch_err_d        = fetch_err_q;
    w_go_req           = 1'b0;
    w_go_pc            = pc_q;

    case (state_q)
      ST_IDLE: w_go_req = 1'b1;
      ST_REQ: begin
        if (req_valid_q && imem_req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (w_pend) begin
            w_go_req = 1'b1;
          end else begin
            inst_d       = imem_resp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_pend) begin
          w_go_req = 1'b1;
        end else if (inst_ready) begin
          w_go_req = 1'b1;
          w_go_pc  = pc_q + INST_BYTES;
        end
      end
      default: begin
        req_valid_d        = 1'b0;
        inst_valid_d       = 1'b0;
        redirect_pending_d = 1'b0;
      end
    endcase

    // Launch the next fetch; a pending redirect overrides the sequential pc.
    if (w_go_req) begin
      inst_valid_d       = 1'b0;
      redirect_pending_d = 1'b0;
      if (w_pend && w_bad) begin
        state_d     = ST_ERR;
        fetch_err_d = 1'b1;
        req_valid_d = 1'b0;
      end else begin
        state_d     = ST_REQ;
        pc_d        = w_pend ? w_tgt : w_go_pc;
        addr_d      = w_pend ? w_tgt : w_go_pc;
        req_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      pc_q               <= RESET_PC;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= RESET_PC;
      redirect_bad_q     <= 1'b0;
      req_valid_q        <= 1'b0;
      addr_q             <= RESET_PC;
      inst_valid_q       <= 1'b0;
      inst_q             <= 32'h0;
      inst_pc_q          <= 32'h0;
      fetch_err_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
      redirect_bad_q     <= redirect_bad_d;
      req_valid_q        <= req_valid_d;
      addr_q             <= addr_d;
      inst_valid_q       <= inst_valid_d;
      inst_q             <= inst_d;
      inst_pc_q          <= inst_pc_d;
      fetch_err_q        <= fetch_err_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = addr_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed vector bench for instr_fetch_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  bit saw_deadbeef = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .next_pc         (next_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) accepts <= accepts + 1;
  end

  always @(negedge clk) begin
    if (inst_valid && inst == 32'hDEADBEEF) saw_deadbeef <= 1'b1;
  end

  typedef struct {
    logic        redir;
    logic [31:0] npc;
    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        iready;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic redir, input logic [31:0] npc, input logic rready,
                              input logic rvalid, input logic [31:0] rdata, input logic iready,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc);
    vec_t v;
    v.redir = redir; v.npc = npc; v.rready = rready; v.rvalid = rvalid;
    v.rdata = rdata; v.iready = iready; v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic drive(input logic redir, input logic [31:0] npc, input logic rready,
                       input logic rvalid, input logic [31:0] rdata, input logic iready);
    redirect        = redir;
    next_pc         = npc;
    imem_req_ready  = rready;
    imem_resp_valid = rvalid;
    imem_resp_data  = rdata;
    inst_ready      = iready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic rv, input logic [31:0] addr,
                           input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                           input logic err);
    total++;
    if (imem_req_valid !== rv || imem_addr !== addr || inst_valid !== iv ||
        inst !== ins || inst_pc !== ipc || fetch_err !== err) begin
      bad++;
      $display("FAIL %s: got rv=%0b addr=%h iv=%0b inst=%h ipc=%h err=%0b want rv=%0b addr=%h iv=%0b inst=%h ipc=%h err=%0b",
               name, imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_err,
               rv, addr, iv, ins, ipc, err);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // redir npc rready rvalid rdata iready | rv addr iv inst ipc
    tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h11111111, 0, 0, 32'h0,        1, 32'h11111111, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h4,        0, 32'h11111111, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h4,        0, 32'h11111111, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h22222222, 0, 0, 32'h4,        1, 32'h22222222, 32'h4));
    tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h4,        1, 32'h22222222, 32'h4));
    tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h22222222, 32'h4));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h8,        0, 32'h22222222, 32'h4));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h33333333, 0, 0, 32'h8,        1, 32'h33333333, 32'h8));
    // redirect coincident with the inst handshake
    tbl.push_back(mk(1, 32'h200,      0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h33333333, 32'h8));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h00000BAD, 0, 1, 32'h200,      0, 32'h33333333, 32'h8));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h200,      0, 32'h33333333, 32'h8));
    // redirect in WAIT, response two cycles later
    tbl.push_back(mk(1, 32'h100,      0, 0, 32'h0,        0, 0, 32'h200,      0, 32'h33333333, 32'h8));
    tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h200,      0, 32'h33333333, 32'h8));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 1, 32'h100,      0, 32'h33333333, 32'h8));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h100,      0, 32'h33333333, 32'h8));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h44444444, 0, 0, 32'h100,      1, 32'h44444444, 32'h100));
    // redirect in HOLD without handshake, then wrap-around
    tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h44444444, 32'h100));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'hFFFFFFFC, 0, 32'h44444444, 32'h100));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h55555555, 0, 0, 32'hFFFFFFFC, 1, 32'h55555555, 32'hFFFFFFFC));
    tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h55555555, 32'hFFFFFFFC));
    // redirect in REQ: request completes unchanged, response dropped
    tbl.push_back(mk(1, 32'h300,      0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h55555555, 32'hFFFFFFFC));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h55555555, 32'hFFFFFFFC));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h66666666, 0, 1, 32'h300,      0, 32'h55555555, 32'hFFFFFFFC));
    // back-to-back redirects: newest target wins
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h300,      0, 32'h55555555, 32'hFFFFFFFC));
    tbl.push_back(mk(1, 32'h400,      0, 0, 32'h0,        0, 0, 32'h300,      0, 32'h55555555, 32'hFFFFFFFC));
    tbl.push_back(mk(1, 32'h500,      0, 0, 32'h0,        0, 0, 32'h300,      0, 32'h55555555, 32'hFFFFFFFC));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h77777777, 0, 1, 32'h500,      0, 32'h55555555, 32'hFFFFFFFC));

    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].redir, tbl[i].npc, tbl[i].rready, tbl[i].rvalid, tbl[i].rdata, tbl[i].iready);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
                tbl[i].e_inst, tbl[i].e_ipc, 1'b0);
    end
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check_val("no_deadbeef", {31'h0, saw_deadbeef}, 32'h0);

    // asynchronous reset while a request is pending
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    rst = 1'b0;

    // redirect in IDLE replaces RESET_PC, then backpressure at 0x10
    drive(1, 32'h10, 0, 0, 32'h0, 0);
    tick();
    check_all("idle_redir", 1, 32'h10, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("bp%0d", i), 1, 32'h10, 0, 32'h0, 32'h0, 0);
    end
    check_val("bp_acc_before", accepts, accepts);
    begin
      int acc0;
      acc0 = accepts;
      drive(0, 32'h0, 1, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        check_all($sformatf("wait%0d", i), 0, 32'h10, 0, 32'h0, 32'h0, 0);
      end
      check_val("one_accept", accepts - acc0, 32'd1);
    end
    drive(0, 32'h0, 0, 1, 32'hAAAA0010, 0);
    tick();
    check_all("bp_resp", 0, 32'h10, 1, 32'hAAAA0010, 32'h10, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    tick();
    check_all("bp_next", 1, 32'h14, 0, 32'hAAAA0010, 32'h10, 0);
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    tick();
    check_all("mis_wait", 0, 32'h14, 0, 32'hAAAA0010, 32'h10, 0);

    // misaligned redirect in WAIT: response absorbed, then error
    drive(1, 32'h102, 0, 0, 32'h0, 0);
    tick();
    check_all("mis_pend", 0, 32'h14, 0, 32'hAAAA0010, 32'h10, 0);
    drive(0, 32'h0, 0, 1, 32'hBBBBBBBB, 0);
    tick();
    check_all("mis_err", 0, 32'h14, 0, 32'hAAAA0010, 32'h10, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40, 1, 1, 32'hCCCCCCCC, 1);
      tick();
      check_val($sformatf("err_sticky%0d", i),
                {29'h0, fetch_err, imem_req_valid, inst_valid}, 32'h4);
    end
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    tick();
    check_all("err_clear", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    rst = 1'b0;
    tick();
    check_all("resume", 1, 32'h0, 0, 32'h0, 32'h0, 0);

    // reset mid-transaction; no response is delivered afterwards
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    tick();
    check_all("pre_rst_wait", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    #1;
    check_all("mid_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    rst = 1'b0;
    tick();
    check_all("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    check_all("post_rst_hold", 1, 32'h0, 0, 32'h0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
